// File: rtl/nbout_buffer_pkg.sv
// -----------------------------------------------------------------------------
// nbout_buffer_pkg
//   Shared defaults and types for the NBout buffer slice.
//   Holds the default parameter values (neuron width, neurons per entry,
//   entry address width, eDRAM address width) and the drain FSM state type.
//   No ports.
// -----------------------------------------------------------------------------
package nbout_buffer_pkg;

  localparam int N_DEF          = 16;
  localparam int TN_DEF         = 1;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int EDRAM_AW_DEF   = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/nbout_buffer_if.sv
// -----------------------------------------------------------------------------
// nbout_buffer_if
//   Valid/ready beat stream from the NBout buffer to the eDRAM write port.
//   Signals:
//     valid  beat valid        (master -> slave)
//     ready  slave accepts     (slave  -> master)
//     data   beat data, E bits (master -> slave)
//     addr   eDRAM word address, AW bits (master -> slave)
//   Modports: master (buffer side), slave (eDRAM side).
// -----------------------------------------------------------------------------
interface nbout_buffer_if #(
  parameter int E  = 16,
  parameter int AW = 20
) ();

  logic          valid;
  logic          ready;
  logic [E-1:0]  data;
  logic [AW-1:0] addr;

  modport master (output valid, output data, output addr, input ready);
  modport slave  (input valid, input data, input addr, output ready);

endinterface

// File: rtl/nbout_buffer_mem.sv
// -----------------------------------------------------------------------------
// nbout_buffer_mem
//   DEPTH x E register file, one write port and two read ports.
//   Ports:
//     clk, rst_n            clock, async active-low reset (preload register only)
//     i_wr_en/i_wr_addr/i_wr_data   synchronous write port
//     i_rd_en/i_rd_addr     registered preload read request
//     o_rd_data             preload data, valid 1 cycle after the request
//     i_drain_addr          combinational drain read address
//     o_drain_data          combinational drain read data
//   The storage array itself is not reset.
// -----------------------------------------------------------------------------
module nbout_buffer_mem
  import nbout_buffer_pkg::*;
#(
  parameter int E          = N_DEF * TN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [E-1:0]          i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [E-1:0]          o_rd_data,
  input  logic [ADDR_WIDTH-1:0] i_drain_addr,
  output logic [E-1:0]          o_drain_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [E-1:0] r_mem [DEPTH];
  logic [E-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Reads sample the array before this edge's write lands, so a same-cycle
  // read and write to one address returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_drain_data = r_mem[i_drain_addr];

endmodule

// File: rtl/nbout_buffer.sv
// -----------------------------------------------------------------------------
// nbout_buffer
//   NBout storage for one DianNao node slice. Captures node results, replays
//   stored partial sums to the node, and drains entries to eDRAM.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     i_wr_en/i_wr_addr/i_node_out   capture node result (IDLE only)
//     i_rd_en/i_rd_addr/o_nbout      registered preload read (any state)
//     i_drain_start/i_drain_count/i_drain_base   drain request
//     edram (master)          valid/ready beat stream to eDRAM
//     o_busy                  drain in progress (STREAM or DONE)
//     o_drain_done            1-cycle pulse after the drain finishes
//     o_err                   sticky: a write was dropped while busy
// -----------------------------------------------------------------------------
module nbout_buffer
  import nbout_buffer_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int Tn         = TN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int EDRAM_AW   = EDRAM_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [N*Tn-1:0]       i_node_out,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [N*Tn-1:0]       o_nbout,
  input  logic                  i_drain_start,
  input  logic [ADDR_WIDTH:0]   i_drain_count,
  input  logic [EDRAM_AW-1:0]   i_drain_base,
  nbout_buffer_if.master        edram,
  output logic                  o_busy,
  output logic                  o_drain_done,
  output logic                  o_err
);

  localparam int E  = N * Tn;
  localparam int CW = ADDR_WIDTH + 1;

  drain_state_t        r_state;
  logic [CW-1:0]       r_idx;
  logic [CW-1:0]       r_count;
  logic [EDRAM_AW-1:0] r_base;
  logic                r_valid;
  logic [E-1:0]        r_data;
  logic [EDRAM_AW-1:0] r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_mem_wr;
  logic [E-1:0]        w_drain_data;
  logic                w_accept;
  logic                w_load;

  // Node results are only captured while no drain is reading the array.
  assign w_mem_wr = i_wr_en && (r_state == ST_IDLE);

  nbout_buffer_mem #(
    .E          (E),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_en      (w_mem_wr),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_node_out),
    .i_rd_en      (i_rd_en),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_nbout),
    .i_drain_addr (r_idx[ADDR_WIDTH-1:0]),
    .o_drain_data (w_drain_data)
  );

  assign w_accept = r_valid && edram.ready;
  // The output register may refill when empty or when its beat leaves this cycle.
  assign w_load   = (!r_valid || edram.ready) && (r_idx < r_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_count <= '0;
      r_base  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_wr_en && (r_state != ST_IDLE)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_drain_start) begin
            r_count <= i_drain_count;
            r_base  <= i_drain_base;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= (i_drain_count == '0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_drain_data;
            r_addr  <= r_base + EDRAM_AW'(r_idx);
            r_idx   <= r_idx + CW'(1);
          end else if (w_accept) begin
            r_valid <= 1'b0;
          end
          // Beats leave in order, so once every index is loaded the beat in
          // the register is index count-1.
          if (w_accept && (r_idx == r_count)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign edram.valid  = r_valid;
  assign edram.data   = r_data;
  assign edram.addr   = r_addr;
  assign o_busy       = r_busy;
  assign o_drain_done = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_nbout_buffer.sv
module tb_nbout_buffer;

  localparam int N  = 16;
  localparam int AW = 6;
  localparam int EA = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [N-1:0]  i_node_out;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [N-1:0]  o_nbout;
  logic          i_drain_start;
  logic [AW:0]   i_drain_count;
  logic [EA-1:0] i_drain_base;
  logic          o_busy;
  logic          o_drain_done;
  logic          o_err;

  nbout_buffer_if #(.E(N), .AW(EA)) u_if ();

  nbout_buffer #(
    .N(N), .Tn(1), .ADDR_WIDTH(AW), .EDRAM_AW(EA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_node_out    (i_node_out),
    .i_rd_en       (i_rd_en),
    .i_rd_addr     (i_rd_addr),
    .o_nbout       (o_nbout),
    .i_drain_start (i_drain_start),
    .i_drain_count (i_drain_count),
    .i_drain_base  (i_drain_base),
    .edram         (u_if),
    .o_busy        (o_busy),
    .o_drain_done  (o_drain_done),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [N-1:0] model [64];
  logic [N-1:0] exp_nb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [N-1:0] d);
    i_wr_en    = 1'b1;
    i_wr_addr  = AW'(a);
    i_node_out = d;
    tick();
    i_wr_en    = 1'b0;
    model[a]   = d;
  endtask

  task automatic rd_check(input string tag, input int a);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(a);
    tick();
    i_rd_en   = 1'b0;
    exp_nb    = model[a];
    check(tag, 32'(o_nbout), 32'(exp_nb));
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: random ready.
  // intr: at the third cycle of the drain, pulse a write and a start.
  task automatic run_drain(input int cnt, input logic [EA-1:0] base, input int mode, input bit intr);
    logic [N-1:0]  exp_d [$];
    logic [EA-1:0] exp_a [$];
    int            cyc, got, first_v, first_a, last_a, done_c, budget;
    logic          rdy, stall;
    logic [N-1:0]  pd;
    logic [EA-1:0] pa;
    for (int i = 0; i < cnt; i++) begin
      exp_d.push_back(model[i]);
      exp_a.push_back(EA'((32'(base) + i) % (1 << EA)));
    end
    budget = cnt * 12 + 20;
    i_drain_count = (AW + 1)'(cnt);
    i_drain_base  = base;
    i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
    cyc = 0; got = 0; first_v = -1; first_a = -1; last_a = -1; done_c = -1;
    stall = 1'b0; pd = '0; pa = '0;
    while (done_c < 0 && cyc < budget) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ((cyc % 3) == 0);
      else                rdy = 1'($urandom_range(0, 1));
      u_if.ready = rdy;
      if (intr && cyc == 2) begin
        i_wr_en       = 1'b1;
        i_wr_addr     = AW'(5);
        i_node_out    = ~model[5];
        i_drain_start = 1'b1;
        i_drain_count = '0;
      end else begin
        i_wr_en       = 1'b0;
        i_drain_start = 1'b0;
      end
      #1;
      if (u_if.valid) begin
        if (first_v < 0) first_v = cyc;
        if (stall) begin
          check("hold_data", 32'(u_if.data), 32'(pd));
          check("hold_addr", 32'(u_if.addr), 32'(pa));
        end
        if (rdy) begin
          if (got < cnt) begin
            check("beat_data", 32'(u_if.data), 32'(exp_d[got]));
            check("beat_addr", 32'(u_if.addr), 32'(exp_a[got]));
          end else begin
            check("extra_beat", 32'(got + 1), 32'(cnt));
          end
          if (first_a < 0) first_a = cyc;
          last_a = cyc;
          got++;
        end
        stall = !rdy;
        pd    = u_if.data;
        pa    = u_if.addr;
      end else begin
        stall = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (o_drain_done) done_c = cyc;
    end
    i_wr_en       = 1'b0;
    i_drain_start = 1'b0;
    check("drain_finished", 32'(done_c >= 0), 32'd1);
    check("beat_count", 32'(got), 32'(cnt));
    if (cnt == 0) begin
      check("done_latency_cnt0", 32'(done_c), 32'd1);
    end else begin
      check("first_valid_latency", 32'(first_v), 32'd1);
      check("done_after_last", 32'(done_c), 32'(last_a + 2));
      if (mode == 0) check("back_to_back", 32'(last_a - first_a), 32'(cnt - 1));
    end
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("err_after_drain", 32'(o_err), 32'(intr));
    u_if.ready = 1'b0;
    tick();
    check("done_pulse_width", 32'(o_drain_done), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    i_wr_en       = 1'b0;
    i_wr_addr     = '0;
    i_node_out    = '0;
    i_rd_en       = 1'b0;
    i_rd_addr     = '0;
    i_drain_start = 1'b0;
    i_drain_count = '0;
    i_drain_base  = '0;
    u_if.ready    = 1'b0;
    exp_nb        = '0;

    // Reset state
    repeat (2) tick();
    check("rst_nbout", 32'(o_nbout), 32'd0);
    check("rst_valid", 32'(u_if.valid), 32'd0);
    check("rst_data", 32'(u_if.data), 32'd0);
    check("rst_addr", 32'(u_if.addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_drain_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write then preload read
    wr(3, 16'h1111);
    rd_check("preload_basic", 3);

    // Same-cycle write and read: old data first, new data afterwards
    i_wr_en    = 1'b1;
    i_wr_addr  = AW'(3);
    i_node_out = 16'h2222;
    i_rd_en    = 1'b1;
    i_rd_addr  = AW'(3);
    tick();
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    check("read_before_write", 32'(o_nbout), 32'h1111);
    model[3] = 16'h2222;
    tick();
    check("preload_holds", 32'(o_nbout), 32'h1111);
    rd_check("read_after_write", 3);

    // Random fill and random preload reads (value holds when rd_en is low)
    for (int k = 0; k < 64; k++) wr(k, 16'($urandom));
    for (int j = 0; j < 20; j++) begin
      int  a;
      logic en;
      a  = int'($urandom_range(0, 63));
      en = 1'($urandom_range(0, 1));
      i_rd_en   = en;
      i_rd_addr = AW'(a);
      tick();
      i_rd_en = 1'b0;
      if (en) exp_nb = model[a];
      check("preload_rand", 32'(o_nbout), 32'(exp_nb));
    end

    // Directed drains
    for (int k = 0; k < 4; k++) wr(k, 16'(k));
    run_drain(4, 20'h00100, 0, 1'b0);
    run_drain(4, 20'h00100, 1, 1'b0);
    run_drain(0, 20'($urandom), 0, 1'b0);
    for (int k = 0; k < 64; k++) wr(k, 16'($urandom));
    run_drain(64, 20'($urandom), 2, 1'b0);
    run_drain(4, 20'hFFFFE, 2, 1'b0);

    // Write and start during a drain: write dropped, start ignored, err sticky
    run_drain(8, 20'h00200, 1, 1'b1);
    check("err_sticky_idle", 32'(o_err), 32'd1);
    rd_check("dropped_write", 5);
    run_drain(3, 20'($urandom), 2, 1'b0);

    // Reset in the middle of a drain
    i_drain_count = 7'd16;
    i_drain_base  = 20'($urandom);
    i_drain_start = 1'b1;
    u_if.ready    = 1'b1;
    tick();
    i_drain_start = 1'b0;
    tick();
    tick();
    check("valid_before_rst", 32'(u_if.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_nbout", 32'(o_nbout), 32'd0);
    check("midrst_valid", 32'(u_if.valid), 32'd0);
    check("midrst_data", 32'(u_if.data), 32'd0);
    check("midrst_addr", 32'(u_if.addr), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_err", 32'(o_err), 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("midrst_no_done", 32'(o_drain_done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      tick();
      check("post_rst_idle_valid", 32'(u_if.valid), 32'd0);
      check("post_rst_no_done", 32'(o_drain_done), 32'd0);
    end
    rd_check("mem_kept_over_rst", 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
